// File: rtl/arm_pkg.sv
// Shared ARM-style core definitions: status register layout,
// EXE command encodings and default datapath widths.
package arm_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } mem_ctrl_t;

  function automatic logic [3:0] pack_nzcv(
    input logic n, input logic z,
    input logic c, input logic v
  );
    logic [3:0] f;
    f       = '0;
    f[SR_N] = n;
    f[SR_Z] = z;
    f[SR_C] = c;
    f[SR_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/status_reg.sv
// NZCV status register with load enable.
// Clears asynchronously so a reset mid-stream drops stale flags.
module status_reg
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] nzcv_in,
  output logic [3:0] sr
);

  logic [3:0] sr_d;
  logic [3:0] sr_q;

  always_comb begin
    sr_d = sr_q;
    if (ld) sr_d = nzcv_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign sr = sr_q;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with NZCV status register,
// freeze/flush handling and a committed-instruction counter.
module exe_mem_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              exe_valid,
  input  logic              s_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              c_in,
  input  logic              v_in,
  output logic [3:0]        sr,
  output logic              alu_c,
  output logic              mem_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_W-1:0]  dest,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic              commit;
  logic              sr_ld;
  logic [3:0]        nzcv;
  mem_ctrl_t         ctrl_d, ctrl_q;
  logic [DATA_W-1:0] alu_res_d, alu_res_q;
  logic [DATA_W-1:0] st_val_d, st_val_q;
  logic [REG_W-1:0]  dest_d, dest_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  assign commit = exe_valid & ~flush & ~freeze;
  assign sr_ld  = commit & s_in;
  assign nzcv   = pack_nzcv(n_in, z_in, c_in, v_in);

  status_reg u_sr (
    .clk     (clk),
    .rst     (rst),
    .ld      (sr_ld),
    .nzcv_in (nzcv),
    .sr      (sr)
  );

  // Controls are gated by exe_valid so a bubble never carries stale enables.
  always_comb begin
    ctrl_d    = ctrl_q;
    alu_res_d = alu_res_q;
    st_val_d  = st_val_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q + CNT_W'(commit);
    if (flush) begin
      ctrl_d = '0;
    end else if (!freeze) begin
      ctrl_d.valid    = exe_valid;
      ctrl_d.wb_en    = exe_valid & wb_en_in;
      ctrl_d.mem_r_en = exe_valid & mem_r_en_in;
      ctrl_d.mem_w_en = exe_valid & mem_w_en_in;
      alu_res_d       = alu_res_in;
      st_val_d        = st_val_in;
      dest_d          = dest_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      alu_res_q <= '0;
      st_val_q  <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      alu_res_q <= alu_res_d;
      st_val_q  <= st_val_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
    end
  end

  assign alu_c      = sr[SR_C];
  assign mem_valid  = ctrl_q.valid;
  assign wb_en      = ctrl_q.wb_en;
  assign mem_r_en   = ctrl_q.mem_r_en;
  assign mem_w_en   = ctrl_q.mem_w_en;
  assign alu_res    = alu_res_q;
  assign st_val     = st_val_q;
  assign dest       = dest_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed + randomised bench for exe_mem_stage_reg with a
// behavioural reference model checked every cycle.
module tb_exe_mem_stage_reg;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 4;

  logic clk = 0;
  logic rst = 1;
  logic freeze = 0, flush = 0, exe_valid = 0, s_in = 0;
  logic wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
  logic [DW-1:0] alu_res_in = '0, st_val_in = '0;
  logic [RW-1:0] dest_in = '0;
  logic n_in = 0, z_in = 0, c_in = 0, v_in = 0;

  logic [3:0] sr;
  logic alu_c, mem_valid, wb_en, mem_r_en, mem_w_en;
  logic [DW-1:0] alu_res, st_val;
  logic [RW-1:0] dest;
  logic [CW-1:0] commit_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit done = 0;

  exe_mem_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .exe_valid(exe_valid), .s_in(s_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .sr(sr), .alu_c(alu_c), .mem_valid(mem_valid), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_res(alu_res),
    .st_val(st_val), .dest(dest), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what MEM must hold after each edge.
  bit      m_valid, m_wb, m_rd, m_wr;
  int      m_res, m_st, m_dest, m_sr, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0;
      m_res = 0; m_st = 0; m_dest = 0; m_sr = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0;
    end else if (!freeze) begin
      m_valid = exe_valid;
      m_wb    = exe_valid && wb_en_in;
      m_rd    = exe_valid && mem_r_en_in;
      m_wr    = exe_valid && mem_w_en_in;
      m_res   = alu_res_in;
      m_st    = st_val_in;
      m_dest  = dest_in;
      if (exe_valid && s_in)
        m_sr = 8 * n_in + 4 * z_in + 2 * c_in + v_in;
      if (exe_valid)
        m_cnt = (m_cnt + 1) % (1 << CW);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("mem_valid", mem_valid, m_valid);
      chk("wb_en", wb_en, m_wb);
      chk("mem_r_en", mem_r_en, m_rd);
      chk("mem_w_en", mem_w_en, m_wr);
      chk("alu_res", alu_res, longint'(unsigned'(m_res)));
      chk("st_val", st_val, longint'(unsigned'(m_st)));
      chk("dest", dest, m_dest);
      chk("sr", sr, m_sr);
      chk("alu_c", alu_c, (m_sr >> 1) & 1);
      chk("commit_cnt", commit_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input bit v, input bit s, input bit wb,
                    input bit rd, input bit wr, input int res,
                    input int st, input int d, input bit [3:0] f);
    exe_valid = v; s_in = s; wb_en_in = wb;
    mem_r_en_in = rd; mem_w_en_in = wr;
    alu_res_in = res; st_val_in = st; dest_in = RW'(d);
    {n_in, z_in, c_in, v_in} = f;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, mem_valid, 0);
    chk({nm, "_ctrl"}, {wb_en, mem_r_en, mem_w_en}, 0);
    chk({nm, "_data"}, {alu_res, st_val, dest}, 0);
    chk({nm, "_sr"}, sr, 0);
    chk({nm, "_alu_c"}, alu_c, 0);
    chk({nm, "_cnt"}, commit_cnt, 0);
  endtask

  initial begin
    step();
    step();
    chk_zero("reset");
    rst = 0;

    // ADD with S: flags 0010
    op(1, 1, 1, 0, 0, 8, 'h11, 3, 4'b0010);
    step();
    chk("t2_alu_res", alu_res, 8);
    chk("t2_dest", dest, 3);
    chk("t2_sr", sr, 4'b0010);
    chk("t2_alu_c", alu_c, 1);
    chk("t2_cnt", commit_cnt, 1);

    // no S: flags ignored
    op(1, 0, 1, 0, 0, 20, 'h22, 5, 4'b1100);
    step();
    chk("t3_sr", sr, 4'b0010);
    chk("t3_alu_res", alu_res, 20);
    chk("t3_dest", dest, 5);
    chk("t3_cnt", commit_cnt, 2);

    // freeze three cycles with changing inputs
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      op(1, 1, 0, 1, 1, 100 + i, i, 9 + i, 4'b1111);
      step();
      chk("t4_alu_res", alu_res, 20);
      chk("t4_dest", dest, 5);
      chk("t4_sr", sr, 4'b0010);
      chk("t4_cnt", commit_cnt, 2);
    end
    freeze = 0;

    // flush kills a flag-setting store
    flush = 1;
    op(1, 1, 0, 0, 1, 44, 'h55, 7, 4'b1001);
    step();
    chk("t5_valid", mem_valid, 0);
    chk("t5_w_en", mem_w_en, 0);
    chk("t5_sr", sr, 4'b0010);
    chk("t5_cnt", commit_cnt, 2);
    flush = 0;

    // real store, then flush+freeze together
    op(1, 0, 0, 0, 1, 64, 'h77, 0, 4'b0000);
    step();
    chk("t6_pre_valid", mem_valid, 1);
    chk("t6_pre_w_en", mem_w_en, 1);
    chk("t6_pre_cnt", commit_cnt, 3);
    flush = 1;
    freeze = 1;
    op(1, 1, 1, 1, 1, 65, 'h78, 1, 4'b1111);
    step();
    chk("t6_valid", mem_valid, 0);
    chk("t6_w_en", mem_w_en, 0);
    chk("t6_sr", sr, 4'b0010);
    chk("t6_cnt", commit_cnt, 3);
    flush = 0;
    freeze = 0;

    // bubble from EXE
    op(0, 1, 1, 1, 1, 66, 'h79, 2, 4'b1111);
    step();
    chk("bub_valid", mem_valid, 0);
    chk("bub_ctrl", {wb_en, mem_r_en, mem_w_en}, 0);
    chk("bub_sr", sr, 4'b0010);
    chk("bub_cnt", commit_cnt, 3);

    // counter wrap
    for (int i = 0; i < 12; i++) begin
      op(1, 0, 1, 0, 0, i, i, i, 4'b0000);
      step();
    end
    chk("t7_full", commit_cnt, 15);
    op(1, 1, 1, 0, 0, 99, 1, 4, 4'b0101);
    step();
    chk("t7_wrap", commit_cnt, 0);
    chk("t7_sr", sr, 4'b0101);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom, $urandom,
         $urandom_range(0, 15), 4'($urandom_range(0, 15)));
      freeze = ($urandom_range(0, 5) == 0);
      flush  = ($urandom_range(0, 6) == 0);
      step();
    end
    freeze = 0;
    flush = 0;

    // mid-stream async reset
    op(1, 1, 1, 1, 1, 'hdead, 'hbeef, 6, 4'b1111);
    step();
    chk("t1_pre_sr", sr, 4'b1111);
    chk("t1_pre_valid", mem_valid, 1);
    rst = 1;
    #1;
    chk_zero("t1_async");
    step();
    rst = 0;
    op(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    step();
    step();
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
